trigger_link_reset_sequencer: RTL and testbench
===============================================

TRIGGER_LINK_RESET_SEQUENCER -- requirements
Module: trigger_link_reset_sequencer

Interface
REQ-001 Parameter ILINKS, default 4: number of trigger TX links supervised.
REQ-002 Parameter PD_CYCLES, default 96: clk_40 cycles PLL is held powered down.
REQ-003 Parameter RST_CYCLES, default 32: clk_40 cycles PLL reset is held after power-up.
REQ-004 Parameter TXRST_CYCLES, default 16: clk_40 cycles TX reset is held after lock.
REQ-005 Parameter LOCK_TIMEOUT, default 4000: maximum wait for PLL lock, in cycles.
REQ-006 Parameter DONE_TIMEOUT, default 4000: maximum wait for all TX reset-done, in cycles.
REQ-007 Parameter MAX_RETRIES, default 3: failed attempts before FAULT.
REQ-008 Ports are as follows; one clock; reset is asynchronous and active-high.
REQ-009 clk_40  input  1  sequencer clock.
REQ-010 reset_i  input  1  asynchronous active-high reset.
REQ-011 force_reset  input  1  synchronous single-cycle restart request (clk_40 domain).
REQ-012 pll_lock  input  1  PLL lock, asynchronous to clk_40.
REQ-013 refclk_lost  input  1  reference clock lost, asynchronous.
REQ-014 tx_resetdone  input  ILINKS  per-link TX reset done, asynchronous.
REQ-015 pll_powerdown  output  1  PLL power-down.
REQ-016 pll_reset  output  1  PLL reset.
REQ-017 tx_reset  output  1  TX reset, common to all links.
REQ-018 ready  output  1  all links up.
REQ-019 fault  output  1  retries exhausted.
REQ-020 state  output  3  current state code.
REQ-021 retry_cnt  output  2  failed attempts in the current sequence.
REQ-022 lock_loss_cnt  output  8  lock losses seen while READY, saturating.

Function
REQ-023 pll_lock, refclk_lost and each tx_resetdone bit pass through a 2-flop synchronizer; the FSM uses only the synchronized copies (2-cycle latency).
REQ-024 States and codes: PWRDN=0, PLLRST=1, WAITLOCK=2, TXRST=3, WAITDONE=4, READY=5, RETRY=6, FAULT=7.
REQ-025 One 16-bit dwell timer clears on every state entry and increments every cycle while in a state.
REQ-026 PWRDN: powerdown=1, pll_reset=1, tx_reset=1; at timer==PD_CYCLES-1 go to PLLRST.
REQ-027 PLLRST: powerdown=0, pll_reset=1, tx_reset=1; at timer==RST_CYCLES-1 go to WAITLOCK.
REQ-028 WAITLOCK: pll_reset=0, tx_reset=1; lock_s=1 goes to TXRST; timer==LOCK_TIMEOUT-1 without lock goes to RETRY; lock takes priority over timeout in the same cycle.
REQ-029 TXRST: tx_reset=1; at timer==TXRST_CYCLES-1 go to WAITDONE; lock_s=0 goes to RETRY.
REQ-030 WAITDONE: tx_reset=0; &resetdone_s goes to READY; lock_s=0 or timer==DONE_TIMEOUT-1 goes to RETRY; lock loss has priority over done.
REQ-031 READY: ready=1, all resets deasserted; lock_s=0 or refclk_lost_s=1 goes to RETRY and increments lock_loss_cnt (saturates at 255).
REQ-032 RETRY lasts exactly one cycle: if retry_cnt==MAX_RETRIES-1 go to FAULT, otherwise increment retry_cnt and go to PWRDN.
REQ-033 FAULT: fault=1, powerdown=1, pll_reset=1, tx_reset=1; remain until force_reset.
REQ-034 Entering READY clears retry_cnt.
REQ-035 force_reset=1 in any state goes to PWRDN next cycle and clears retry_cnt and fault; lock_loss_cnt is kept. force_reset has priority over all other transitions.
REQ-036 All outputs are registered and decoded from the state register, with no combinational path from inputs.
REQ-037 refclk_lost_s=1 in WAITLOCK, TXRST or WAITDONE goes to RETRY.

Reset
REQ-038 reset_i asserted asynchronously forces state=PWRDN, timer=0, powerdown=1, pll_reset=1, tx_reset=1, ready=0, fault=0, retry_cnt=0, lock_loss_cnt=0, and clears the synchronizers.
REQ-039 On reset_i release, sequencing starts from PWRDN at the first clk_40 edge; reset mid-sequence fully aborts the sequence.

Verification
REQ-040 Clean bring-up: lock rises 10 cycles into WAITLOCK, all resetdone rise 20 cycles into WAITDONE -> ready=1 at cycle 96+32+12+16+22 (±1), retry_cnt=0.
REQ-041 No lock ever -> RETRY after 4000 cycles in WAITLOCK, three attempts, then fault=1, state=7, outputs held in reset.
REQ-042 One link's resetdone stuck low (0b0111) -> RETRY on DONE_TIMEOUT, retry_cnt increments, ready stays 0.
REQ-043 In READY, drop pll_lock for 1 cycle -> RETRY within 3 cycles, lock_loss_cnt=1, resequence back to READY.
REQ-044 force_reset in FAULT, and separately in WAITDONE -> PWRDN next cycle, fault=0, retry_cnt=0; 300 forced losses -> lock_loss_cnt=255.
REQ-045 Assert reset_i mid-WAITDONE between clock edges -> outputs reach reset values immediately (asynchronously), and after release the sequence restarts from PWRDN.

Source files
------------

// File: rtl/trigger_link_reset_sequencer.sv
// Power-up / reset sequencer for a group of trigger TX links sharing one PLL.
// Walks PLL power-down, PLL reset, lock wait, TX reset and reset-done wait, with retry and fault handling.
module trigger_link_reset_sequencer #(
    parameter int unsigned ILINKS       = 4,
    parameter int unsigned PD_CYCLES    = 96,
    parameter int unsigned RST_CYCLES   = 32,
    parameter int unsigned TXRST_CYCLES = 16,
    parameter int unsigned LOCK_TIMEOUT = 4000,
    parameter int unsigned DONE_TIMEOUT = 4000,
    parameter int unsigned MAX_RETRIES  = 3
) (
    input  logic              clk_40,
    input  logic              reset_i,
    input  logic              force_reset,
    input  logic              pll_lock,
    input  logic              refclk_lost,
    input  logic [ILINKS-1:0] tx_resetdone,
    output logic              pll_powerdown,
    output logic              pll_reset,
    output logic              tx_reset,
    output logic              ready,
    output logic              fault,
    output logic [2:0]        state,
    output logic [1:0]        retry_cnt,
    output logic [7:0]        lock_loss_cnt
);

    typedef enum logic [2:0] {
        S_PWRDN    = 3'd0,
        S_PLLRST   = 3'd1,
        S_WAITLOCK = 3'd2,
        S_TXRST    = 3'd3,
        S_WAITDONE = 3'd4,
        S_READY    = 3'd5,
        S_RETRY    = 3'd6,
        S_FAULT    = 3'd7
    } state_t;

    localparam logic [15:0] PD_LAST    = 16'(PD_CYCLES - 1);
    localparam logic [15:0] RST_LAST   = 16'(RST_CYCLES - 1);
    localparam logic [15:0] TXRST_LAST = 16'(TXRST_CYCLES - 1);
    localparam logic [15:0] LOCK_LAST  = 16'(LOCK_TIMEOUT - 1);
    localparam logic [15:0] DONE_LAST  = 16'(DONE_TIMEOUT - 1);
    localparam logic [1:0]  RETRY_LAST = 2'(MAX_RETRIES - 1);

    logic              r_lock_meta, r_lock_s;
    logic              r_refclk_meta, r_refclk_s;
    logic [ILINKS-1:0] r_done_meta, r_done_s;

    state_t      r_state;
    state_t      w_next;
    logic [15:0] r_timer;
    logic [1:0]  r_retry_cnt;
    logic [7:0]  r_lock_loss_cnt;
    logic        r_pll_powerdown, r_pll_reset, r_tx_reset, r_ready, r_fault;
    logic        w_link_bad;

    always_ff @(posedge clk_40 or posedge reset_i) begin
        if (reset_i) begin
            r_lock_meta   <= 1'b0;
            r_lock_s      <= 1'b0;
            r_refclk_meta <= 1'b0;
            r_refclk_s    <= 1'b0;
            r_done_meta   <= '0;
            r_done_s      <= '0;
        end else begin
            r_lock_meta   <= pll_lock;
            r_lock_s      <= r_lock_meta;
            r_refclk_meta <= refclk_lost;
            r_refclk_s    <= r_refclk_meta;
            r_done_meta   <= tx_resetdone;
            r_done_s      <= r_done_meta;
        end
    end

    assign w_link_bad = !r_lock_s || r_refclk_s;

    always_comb begin
        w_next = r_state;
        if (force_reset) begin
            w_next = S_PWRDN;
        end else begin
            case (r_state)
                S_PWRDN:    if (r_timer == PD_LAST) w_next = S_PLLRST;
                S_PLLRST:   if (r_timer == RST_LAST) w_next = S_WAITLOCK;
                S_WAITLOCK: begin
                    if (r_refclk_s)                 w_next = S_RETRY;
                    else if (r_lock_s)              w_next = S_TXRST;
                    else if (r_timer == LOCK_LAST)  w_next = S_RETRY;
                end
                S_TXRST: begin
                    if (w_link_bad)                 w_next = S_RETRY;
                    else if (r_timer == TXRST_LAST) w_next = S_WAITDONE;
                end
                // Completion wins over a coincident timeout, as lock does in WAITLOCK.
                S_WAITDONE: begin
                    if (w_link_bad)                 w_next = S_RETRY;
                    else if (&r_done_s)             w_next = S_READY;
                    else if (r_timer == DONE_LAST)  w_next = S_RETRY;
                end
                S_READY:    if (w_link_bad) w_next = S_RETRY;
                S_RETRY:    w_next = (r_retry_cnt == RETRY_LAST) ? S_FAULT : S_PWRDN;
                S_FAULT:    w_next = S_FAULT;
                default:    w_next = S_PWRDN;
            endcase
        end
    end

    // Outputs are decoded from the next state so they change on the same edge as r_state.
    always_ff @(posedge clk_40 or posedge reset_i) begin
        if (reset_i) begin
            r_state         <= S_PWRDN;
            r_timer         <= '0;
            r_retry_cnt     <= '0;
            r_lock_loss_cnt <= '0;
            r_pll_powerdown <= 1'b1;
            r_pll_reset     <= 1'b1;
            r_tx_reset      <= 1'b1;
            r_ready         <= 1'b0;
            r_fault         <= 1'b0;
        end else begin
            r_state <= w_next;

            if (force_reset || (w_next != r_state))
                r_timer <= '0;
            else if (r_timer != '1)
                r_timer <= r_timer + 16'd1;

            if (force_reset)
                r_retry_cnt <= '0;
            else if (r_state == S_RETRY && w_next == S_PWRDN)
                r_retry_cnt <= r_retry_cnt + 2'd1;
            else if (r_state != S_READY && w_next == S_READY)
                r_retry_cnt <= '0;

            if (r_state == S_READY && w_next == S_RETRY && r_lock_loss_cnt != '1)
                r_lock_loss_cnt <= r_lock_loss_cnt + 8'd1;

            r_pll_powerdown <= 1'b0;
            r_pll_reset     <= 1'b0;
            r_tx_reset      <= 1'b0;
            r_ready         <= 1'b0;
            r_fault         <= 1'b0;
            case (w_next)
                S_PWRDN, S_RETRY: begin
                    r_pll_powerdown <= 1'b1;
                    r_pll_reset     <= 1'b1;
                    r_tx_reset      <= 1'b1;
                end
                S_PLLRST: begin
                    r_pll_reset <= 1'b1;
                    r_tx_reset  <= 1'b1;
                end
                S_WAITLOCK, S_TXRST: r_tx_reset <= 1'b1;
                S_READY:             r_ready    <= 1'b1;
                S_FAULT: begin
                    r_pll_powerdown <= 1'b1;
                    r_pll_reset     <= 1'b1;
                    r_tx_reset      <= 1'b1;
                    r_fault         <= 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign pll_powerdown = r_pll_powerdown;
    assign pll_reset     = r_pll_reset;
    assign tx_reset      = r_tx_reset;
    assign ready         = r_ready;
    assign fault         = r_fault;
    assign state         = r_state;
    assign retry_cnt     = r_retry_cnt;
    assign lock_loss_cnt = r_lock_loss_cnt;

endmodule

// File: tb/tb_trigger_link_reset_sequencer.sv
// Directed bench for trigger_link_reset_sequencer with default parameters.
// Inputs change on the falling edge; outputs are checked on the falling edge after the edge of interest.
module tb_trigger_link_reset_sequencer;

    logic       clk_40 = 1'b0;
    logic       reset_i;
    logic       force_reset;
    logic       pll_lock;
    logic       refclk_lost;
    logic [3:0] tx_resetdone;
    logic       pll_powerdown, pll_reset, tx_reset, ready, fault;
    logic [2:0] state;
    logic [1:0] retry_cnt;
    logic [7:0] lock_loss_cnt;

    int n_assert = 0;
    int n_fail   = 0;

    trigger_link_reset_sequencer #(
        .ILINKS(4), .PD_CYCLES(96), .RST_CYCLES(32), .TXRST_CYCLES(16),
        .LOCK_TIMEOUT(4000), .DONE_TIMEOUT(4000), .MAX_RETRIES(3)
    ) dut (
        .clk_40        (clk_40),
        .reset_i       (reset_i),
        .force_reset   (force_reset),
        .pll_lock      (pll_lock),
        .refclk_lost   (refclk_lost),
        .tx_resetdone  (tx_resetdone),
        .pll_powerdown (pll_powerdown),
        .pll_reset     (pll_reset),
        .tx_reset      (tx_reset),
        .ready         (ready),
        .fault         (fault),
        .state         (state),
        .retry_cnt     (retry_cnt),
        .lock_loss_cnt (lock_loss_cnt)
    );

    always #5 clk_40 = ~clk_40;

    task automatic cyc(input int n);
        repeat (n) @(negedge clk_40);
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic chk_outs(input string tag, input logic [2:0] st, input logic [4:0] pprrf);
        chk({tag, "_state"}, 32'(state), 32'(st));
        chk({tag, "_outs"}, 32'({pll_powerdown, pll_reset, tx_reset, ready, fault}), 32'(pprrf));
    endtask

    initial begin
        reset_i      = 1'b1;
        force_reset  = 1'b0;
        pll_lock     = 1'b0;
        refclk_lost  = 1'b0;
        tx_resetdone = 4'b0000;
        cyc(3);
        chk_outs("reset", 3'd0, 5'b11100);
        chk("reset_retry", 32'(retry_cnt), 0);
        chk("reset_llc", 32'(lock_loss_cnt), 0);

        // Clean bring-up; edge numbers counted from reset release.
        reset_i = 1'b0;
        cyc(95);  chk("pwrdn_dwell", 32'(state), 0);
        cyc(1);   chk_outs("pllrst_entry", 3'd1, 5'b01100);
        cyc(32);  chk_outs("waitlock_entry", 3'd2, 5'b00100);
        cyc(9);   pll_lock = 1'b1;
        cyc(2);   chk("lock_sync_latency", 32'(state), 2);
        cyc(1);   chk_outs("txrst_entry", 3'd3, 5'b00100);
        cyc(16);  chk_outs("waitdone_entry", 3'd4, 5'b00000);
        cyc(19);  tx_resetdone = 4'b1111;
        cyc(2);   chk("ready_edge177", 32'(ready), 0);
        cyc(1);   chk_outs("ready_edge178", 3'd5, 5'b00010);
        chk("bringup_retry", 32'(retry_cnt), 0);

        // One-cycle lock drop in READY.
        cyc(5);   pll_lock = 1'b0;
        cyc(1);   pll_lock = 1'b1;
        cyc(1);   chk("lockdrop_e2", 32'(state), 5);
        cyc(1);   chk("lockdrop_retry", 32'(state), 6);
        chk("lockdrop_llc", 32'(lock_loss_cnt), 1);
        cyc(1);   chk_outs("lockdrop_pwrdn", 3'd0, 5'b11100);
        chk("lockdrop_retrycnt", 32'(retry_cnt), 1);
        cyc(145); chk("relock_waitdone", 32'(state), 4);
        cyc(1);   chk_outs("relock_ready", 3'd5, 5'b00010);
        chk("relock_retry_clr", 32'(retry_cnt), 0);

        // Reference clock loss in READY.
        cyc(3);   refclk_lost = 1'b1;
        cyc(1);   refclk_lost = 1'b0;
        cyc(2);   chk("refclk_retry", 32'(state), 6);
        chk("refclk_llc", 32'(lock_loss_cnt), 2);
        cyc(1);   chk("refclk_pwrdn", 32'(state), 0);
        cyc(146); chk("refclk_ready", 32'(ready), 1);

        // One link never finishes reset: DONE_TIMEOUT path.
        tx_resetdone = 4'b0111;
        force_reset  = 1'b1;
        cyc(1);   force_reset = 1'b0;
        chk_outs("force_ready", 3'd0, 5'b11100);
        chk("force_keeps_llc", 32'(lock_loss_cnt), 2);
        cyc(145);  chk("stuck_waitdone", 32'(state), 4);
        cyc(3999); chk_outs("stuck_before_to", 3'd4, 5'b00000);
        cyc(1);    chk("stuck_timeout", 32'(state), 6);
        cyc(1);    chk("stuck_pwrdn", 32'(state), 0);
        chk("stuck_retrycnt", 32'(retry_cnt), 1);
        cyc(145);  chk("stuck_waitdone2", 32'(state), 4);
        chk("stuck_retrycnt2", 32'(retry_cnt), 1);
        cyc(10);   force_reset = 1'b1;
        cyc(1);    force_reset = 1'b0;
        chk_outs("force_waitdone", 3'd0, 5'b11100);
        chk("force_waitdone_retry", 32'(retry_cnt), 0);

        // No lock: three LOCK_TIMEOUT attempts then FAULT.
        pll_lock = 1'b0;
        cyc(128);  chk("nolock_waitlock", 32'(state), 2);
        cyc(3999); chk("nolock_before_to", 32'(state), 2);
        cyc(1);    chk("nolock_retry1", 32'(state), 6);
        cyc(1);    chk("nolock_retrycnt1", 32'(retry_cnt), 1);
        cyc(4128); chk("nolock_retry2", 32'(state), 6);
        cyc(1);    chk("nolock_retrycnt2", 32'(retry_cnt), 2);
        cyc(4128); chk("nolock_retry3", 32'(state), 6);
        cyc(1);    chk_outs("nolock_fault", 3'd7, 5'b11101);
        chk("fault_retrycnt", 32'(retry_cnt), 2);
        cyc(50);   chk_outs("fault_hold", 3'd7, 5'b11101);

        // Leave FAULT, then hit reset_i asynchronously mid-WAITDONE.
        pll_lock     = 1'b1;
        tx_resetdone = 4'b0000;
        force_reset  = 1'b1;
        cyc(1);    force_reset = 1'b0;
        chk_outs("force_fault", 3'd0, 5'b11100);
        chk("force_fault_retry", 32'(retry_cnt), 0);
        cyc(150);  chk("async_pre", 32'(state), 4);
        #2 reset_i = 1'b1;
        #1;
        chk_outs("async_reset", 3'd0, 5'b11100);
        chk("async_retry", 32'(retry_cnt), 0);
        chk("async_llc", 32'(lock_loss_cnt), 0);
        cyc(1);    reset_i = 1'b0;
        cyc(95);   chk("restart_pwrdn", 32'(state), 0);
        cyc(1);    chk("restart_pllrst", 32'(state), 1);
        tx_resetdone = 4'b1111;
        cyc(49);   chk("restart_waitdone", 32'(state), 4);
        cyc(1);    chk_outs("restart_ready", 3'd5, 5'b00010);

        // 300 lock losses saturate the counter at 255.
        for (int i = 0; i < 300; i++) begin
            cyc(2);   pll_lock = 1'b0;
            cyc(1);   pll_lock = 1'b1;
            cyc(2);   chk("loop_retry", 32'(state), 6);
            cyc(147); chk("loop_ready", 32'(ready), 1);
            if (i == 253) chk("llc_254", 32'(lock_loss_cnt), 254);
            if (i == 254) chk("llc_255", 32'(lock_loss_cnt), 255);
        end
        chk("llc_saturated", 32'(lock_loss_cnt), 255);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
